// File: rtl/stack_rpn_sequencer.sv
// RPN token sequencer: turns operand/operator tokens into push/pop/get commands
// for an attached hardware stack. It does the 4-bit ALU work locally and
// reports results, committed depth and errors.
module stack_rpn_sequencer #(
  parameter int unsigned DEPTH_MAX = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       I_VALID,
  output logic       O_READY,
  input  logic       I_KIND,
  input  logic [3:0] I_TOKEN,
  output logic [1:0] O_COMMAND,
  output logic [2:0] O_INDEX,
  output logic [3:0] O_PUSH_DATA,
  input  logic [3:0] I_STACK_DATA,
  output logic [3:0] O_RESULT,
  output logic       O_RESULT_VALID,
  output logic [2:0] O_DEPTH,
  output logic       O_ERROR,
  output logic [1:0] O_ERR_CODE
);

  localparam logic [2:0] DepthMax = 3'(DEPTH_MAX);

  localparam logic [1:0] CmdNone = 2'b00;
  localparam logic [1:0] CmdPush = 2'b01;
  localparam logic [1:0] CmdPop  = 2'b10;
  localparam logic [1:0] CmdGet  = 2'b11;

  localparam logic [1:0] ErrUnder   = 2'b01;
  localparam logic [1:0] ErrOver    = 2'b10;
  localparam logic [1:0] ErrIllegal = 2'b11;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpDup  = 4'd5;
  localparam logic [3:0] OpDrop = 4'd6;

  typedef enum logic [3:0] {
    StIdle,
    StPush,
    StPopB,
    StPopA,
    StCalc,
    StPushR,
    StGet,
    StCapt,
    StReport
  } state_e;

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic [1:0] command_q, command_d;
  logic [2:0] index_q, index_d;
  logic [3:0] push_data_q, push_data_d;
  logic [3:0] result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic [2:0] depth_q, depth_d;
  logic       error_q, error_d;
  logic [1:0] err_code_q, err_code_d;
  logic [3:0] op_q, op_d;
  logic [3:0] b_q, b_d;

  // a is the entry below the top, b is the top; carry and borrow are dropped
  function automatic logic [3:0] alu(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b);
    logic [3:0] r;
    r = 4'd0;
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= StIdle;
      ready_q        <= 1'b1;
      command_q      <= CmdNone;
      index_q        <= 3'd0;
      push_data_q    <= 4'd0;
      result_q       <= 4'd0;
      result_valid_q <= 1'b0;
      depth_q        <= 3'd0;
      error_q        <= 1'b0;
      err_code_q     <= 2'b00;
      op_q           <= 4'd0;
      b_q            <= 4'd0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      command_q      <= command_d;
      index_q        <= index_d;
      push_data_q    <= push_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      depth_q        <= depth_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      op_q           <= op_d;
      b_q            <= b_d;
    end
  end

  // Next-state decode, precondition checks and command sequencing
  always_comb begin
    state_d        = state_q;
    command_d      = CmdNone;
    index_d        = 3'd0;
    push_data_d    = push_data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    error_d        = error_q;
    err_code_d     = err_code_q;
    op_d           = op_q;
    b_d            = b_q;

    // Depth tracks the command being driven now; the stack commits it on this edge
    unique case (command_q)
      CmdPush: depth_d = depth_q + 3'd1;
      CmdPop:  depth_d = depth_q - 3'd1;
      default: depth_d = depth_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (I_VALID) begin
          if (!I_KIND) begin
            if (depth_q == DepthMax) begin
              error_d    = 1'b1;
              err_code_d = ErrOver;
            end else begin
              state_d     = StPush;
              command_d   = CmdPush;
              push_data_d = I_TOKEN;
            end
          end else begin
            op_d = I_TOKEN;
            case (I_TOKEN)
              OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
                if (depth_q < 3'd2) begin
                  error_d    = 1'b1;
                  err_code_d = ErrUnder;
                end else begin
                  state_d   = StPopB;
                  command_d = CmdPop;
                end
              end
              OpDup: begin
                if (depth_q == 3'd0) begin
                  error_d    = 1'b1;
                  err_code_d = ErrUnder;
                end else if (depth_q == DepthMax) begin
                  error_d    = 1'b1;
                  err_code_d = ErrOver;
                end else begin
                  state_d   = StGet;
                  command_d = CmdGet;
                  index_d   = 3'd0;
                end
              end
              OpDrop: begin
                if (depth_q == 3'd0) begin
                  error_d    = 1'b1;
                  err_code_d = ErrUnder;
                end else begin
                  state_d   = StPopB;
                  command_d = CmdPop;
                end
              end
              4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
                if (depth_q <= I_TOKEN[2:0]) begin
                  error_d    = 1'b1;
                  err_code_d = ErrUnder;
                end else begin
                  state_d   = StGet;
                  command_d = CmdGet;
                  index_d   = I_TOKEN[2:0];
                end
              end
              default: begin
                error_d    = 1'b1;
                err_code_d = ErrIllegal;
              end
            endcase
          end
        end
      end
      StPush: state_d = StIdle;
      StPopB: begin
        if (op_q == OpDrop) begin
          state_d = StIdle;
        end else begin
          state_d   = StPopA;
          command_d = CmdPop;
        end
      end
      StPopA: begin
        // B popped by the previous command is on the read port now
        b_d     = I_STACK_DATA;
        state_d = StCalc;
      end
      StCalc: begin
        push_data_d    = alu(op_q, I_STACK_DATA, b_q);
        result_d       = alu(op_q, I_STACK_DATA, b_q);
        result_valid_d = 1'b1;
        command_d      = CmdPush;
        state_d        = StPushR;
      end
      StPushR: state_d = StIdle;
      StGet:   state_d = StCapt;
      StCapt: begin
        if (op_q == OpDup) begin
          push_data_d = I_STACK_DATA;
          command_d   = CmdPush;
          state_d     = StPushR;
        end else begin
          result_d       = I_STACK_DATA;
          result_valid_d = 1'b1;
          state_d        = StReport;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  assign O_READY        = ready_q;
  assign O_COMMAND      = command_q;
  assign O_INDEX        = index_q;
  assign O_PUSH_DATA    = push_data_q;
  assign O_RESULT       = result_q;
  assign O_RESULT_VALID = result_valid_q;
  assign O_DEPTH        = depth_q;
  assign O_ERROR        = error_q;
  assign O_ERR_CODE     = err_code_q;

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Directed bench for stack_rpn_sequencer with a behavioural 5-entry stack attached.
module tb_stack_rpn_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       I_VALID;
  logic       O_READY;
  logic       I_KIND;
  logic [3:0] I_TOKEN;
  logic [1:0] O_COMMAND;
  logic [2:0] O_INDEX;
  logic [3:0] O_PUSH_DATA;
  logic [3:0] I_STACK_DATA;
  logic [3:0] O_RESULT;
  logic       O_RESULT_VALID;
  logic [2:0] O_DEPTH;
  logic       O_ERROR;
  logic [1:0] O_ERR_CODE;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent token
  int          lat;
  logic [31:0] trace;
  int          nstb;
  int          stb_cyc;
  logic [3:0]  res;

  always #5 CLK = ~CLK;

  stack_rpn_sequencer #(.DEPTH_MAX(5)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .I_VALID        (I_VALID),
    .O_READY        (O_READY),
    .I_KIND         (I_KIND),
    .I_TOKEN        (I_TOKEN),
    .O_COMMAND      (O_COMMAND),
    .O_INDEX        (O_INDEX),
    .O_PUSH_DATA    (O_PUSH_DATA),
    .I_STACK_DATA   (I_STACK_DATA),
    .O_RESULT       (O_RESULT),
    .O_RESULT_VALID (O_RESULT_VALID),
    .O_DEPTH        (O_DEPTH),
    .O_ERROR        (O_ERROR),
    .O_ERR_CODE     (O_ERR_CODE)
  );

  // Stack model: command executes on the edge, read data valid the cycle after
  logic [3:0] smem [5];
  logic [2:0] sp;
  logic [3:0] sdata;
  assign I_STACK_DATA = sdata;

  always @(posedge CLK) begin
    if (RESET) begin
      sp    <= 3'd0;
      sdata <= 4'd0;
    end else begin
      case (O_COMMAND)
        2'b01: if (sp < 3'd5) begin
          smem[sp] <= O_PUSH_DATA;
          sp       <= sp + 3'd1;
        end
        2'b10: if (sp > 3'd0) begin
          sdata <= smem[sp - 3'd1];
          sp    <= sp - 3'd1;
        end
        2'b11: if (sp > O_INDEX) sdata <= smem[sp - 3'd1 - O_INDEX];
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, 32'(O_READY), 1);
    check_eq({tag, "_cmd"}, 32'(O_COMMAND), 0);
    check_eq({tag, "_index"}, 32'(O_INDEX), 0);
    check_eq({tag, "_pdata"}, 32'(O_PUSH_DATA), 0);
    check_eq({tag, "_result"}, 32'(O_RESULT), 0);
    check_eq({tag, "_rvalid"}, 32'(O_RESULT_VALID), 0);
    check_eq({tag, "_depth"}, 32'(O_DEPTH), 0);
    check_eq({tag, "_error"}, 32'(O_ERROR), 0);
    check_eq({tag, "_code"}, 32'(O_ERR_CODE), 0);
  endtask

  // Present one token, then follow the sequence until O_READY returns
  task automatic send(input logic kind, input logic [3:0] tok);
    int cyc;
    I_VALID = 1'b1;
    I_KIND  = kind;
    I_TOKEN = tok;
    @(posedge CLK);
    #1;
    I_VALID = 1'b0;
    trace   = 32'd0;
    nstb    = 0;
    stb_cyc = 0;
    res     = 4'd0;
    cyc     = 1;
    while (!O_READY && cyc < 20) begin
      trace = {trace[29:0], O_COMMAND};
      if (O_RESULT_VALID) begin
        nstb++;
        stb_cyc = cyc;
        res     = O_RESULT;
      end
      @(posedge CLK);
      #1;
      cyc++;
    end
    lat = cyc;
    if (!O_READY) check_eq("send_timeout", 32'(O_READY), 1);
  endtask

  task automatic push(input logic [3:0] v);
    send(1'b0, v);
  endtask

  initial begin
    RESET   = 1'b1;
    I_VALID = 1'b0;
    I_KIND  = 1'b0;
    I_TOKEN = 4'd0;
    do_reset();
    check_reset("rst0");

    // 3 + 5
    push(4'd3);
    check_eq("push_lat", lat, 2);
    check_eq("push_trace", trace, 32'h1);
    push(4'd5);
    send(1'b1, 4'd0);
    check_eq("add_trace", trace, 32'hA1);
    check_eq("add_lat", lat, 5);
    check_eq("add_nstb", nstb, 1);
    check_eq("add_stbcyc", stb_cyc, 4);
    check_eq("add_res", 32'(res), 8);
    check_eq("add_depth", 32'(O_DEPTH), 1);
    send(1'b1, 4'd8);
    check_eq("peek0_trace", trace, 32'h30);
    check_eq("peek0_lat", lat, 4);
    check_eq("peek0_nstb", nstb, 1);
    check_eq("peek0_res", 32'(res), 8);

    // SUB with borrow, ADD with carry out
    do_reset();
    push(4'd2);
    push(4'd7);
    send(1'b1, 4'd1);
    check_eq("sub_res", 32'(res), 32'hB);
    push(4'd15);
    push(4'd1);
    send(1'b1, 4'd0);
    check_eq("addwrap_res", 32'(res), 0);
    check_eq("addwrap_nstb", nstb, 1);
    check_eq("addwrap_depth", 32'(O_DEPTH), 2);
    check_eq("noerr", 32'(O_ERROR), 0);

    // Overflow on the sixth operand
    do_reset();
    for (int i = 1; i <= 5; i++) push(4'(i));
    push(4'd6);
    check_eq("ovf_lat", lat, 1);
    check_eq("ovf_cmd", 32'(O_COMMAND), 0);
    check_eq("ovf_error", 32'(O_ERROR), 1);
    check_eq("ovf_code", 32'(O_ERR_CODE), 2);
    check_eq("ovf_depth", 32'(O_DEPTH), 5);
    check_eq("ovf_sp", 32'(sp), 5);
    send(1'b1, 4'd12);
    check_eq("peek4_res", 32'(res), 1);
    send(1'b1, 4'd8);
    check_eq("peek0b_res", 32'(res), 5);

    // Underflow, illegal opcode, then a good ADD
    do_reset();
    push(4'd4);
    send(1'b1, 4'd0);
    check_eq("und_lat", lat, 1);
    check_eq("und_trace", trace, 0);
    check_eq("und_cmd", 32'(O_COMMAND), 0);
    check_eq("und_code", 32'(O_ERR_CODE), 1);
    check_eq("und_depth", 32'(O_DEPTH), 1);
    send(1'b1, 4'd7);
    check_eq("ill_code", 32'(O_ERR_CODE), 3);
    push(4'd9);
    send(1'b1, 4'd0);
    check_eq("add13_res", 32'(res), 13);
    check_eq("sticky_err", 32'(O_ERROR), 1);
    check_eq("sticky_code", 32'(O_ERR_CODE), 3);

    // DUP, PEEK 1, DROP
    do_reset();
    push(4'd9);
    send(1'b1, 4'd5);
    check_eq("dup_trace", trace, 32'h31);
    check_eq("dup_lat", lat, 4);
    check_eq("dup_nstb", nstb, 0);
    check_eq("dup_depth", 32'(O_DEPTH), 2);
    send(1'b1, 4'd9);
    check_eq("peek1_res", 32'(res), 9);
    check_eq("peek1_depth", 32'(O_DEPTH), 2);
    send(1'b1, 4'd6);
    check_eq("drop_trace", trace, 32'h2);
    check_eq("drop_lat", lat, 2);
    check_eq("drop_depth", 32'(O_DEPTH), 1);

    // Reset during POP_A abandons the ADD
    do_reset();
    push(4'd1);
    push(4'd2);
    I_VALID = 1'b1;
    I_KIND  = 1'b1;
    I_TOKEN = 4'd0;
    @(posedge CLK);
    #1;
    I_VALID = 1'b0;
    check_eq("popb_cmd", 32'(O_COMMAND), 2);
    @(posedge CLK);
    #1;
    check_eq("popa_cmd", 32'(O_COMMAND), 2);
    check_eq("popa_ready", 32'(O_READY), 0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_reset("rst_mid");
    send(1'b1, 4'd8);
    check_eq("postrst_code", 32'(O_ERR_CODE), 1);
    check_eq("postrst_err", 32'(O_ERROR), 1);
    check_eq("postrst_depth", 32'(O_DEPTH), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
